// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 divider: radix-2 restoring mantissa division, one quotient bit per
// cycle, round-to-nearest-even, subnormals flushed to zero, valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for operands; special cases resolved at acceptance
// DIV   | one restoring division step per cycle
// ROUND | rounding, range check and result packing
// DONE  | result held until out_ready
module fp_div_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] q,
    output logic [4:0]           flags,
    output logic                 busy
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int EW    = EXP_W + 2;
    localparam int CNT_W = $clog2(MAN_W + 3);

    localparam logic [EW-1:0]        BIAS_E   = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_OVF  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(MAN_W + 1);
    localparam logic [W-1:0]         QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

    state_t                 state_q;
    logic                   in_ready_q, busy_q, out_valid_q, sign_q;
    logic [W-1:0]           res_q;
    logic [4:0]             flags_q;
    logic [MAN_W+1:0]       rem_q;
    logic [MAN_W:0]         mb_q, quot_q;
    logic signed [EW-1:0]   exp_q;
    logic [CNT_W-1:0]       cnt_q;

    logic                   sa, sb, sr;
    logic [EXP_W-1:0]       ea, eb;
    logic [MAN_W-1:0]       fa, fb;
    logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;

    assign {sa, ea, fa} = a;
    assign {sb, eb, fb} = b;
    assign sr     = sa ^ sb;
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (&ea) && (fa == '0);
    assign b_inf  = (&eb) && (fb == '0);
    assign a_nan  = (&ea) && (fa != '0);
    assign b_nan  = (&eb) && (fb != '0);
    assign a_snan = a_nan && !fa[MAN_W-1];
    assign b_snan = b_nan && !fb[MAN_W-1];

    logic           sp_hit;
    logic [W-1:0]   sp_res;
    logic [4:0]     sp_flags;

    // inf/0 falls into the inf/finite case: infinite result without divzero
    always_comb begin
        sp_hit   = 1'b1;
        sp_res   = '0;
        sp_flags = '0;
        if (a_nan || b_nan) begin
            sp_res   = QNAN;
            sp_flags = {a_snan | b_snan, 4'b0000};
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            sp_res   = QNAN;
            sp_flags = 5'b10000;
        end else if (a_inf) begin
            sp_res = {sr, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_zero) begin
            sp_res   = {sr, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            sp_flags = 5'b01000;
        end else if (a_zero || b_inf) begin
            sp_res = {sr, {(W-1){1'b0}}};
        end else begin
            sp_hit = 1'b0;
        end
    end

    logic [MAN_W:0]       ma, mb;
    logic                 ma_lt;
    logic [MAN_W+1:0]     rem_init;
    logic [EW-1:0]        e_diff;
    logic signed [EW-1:0] e_init;

    assign ma       = {1'b1, fa};
    assign mb       = {1'b1, fb};
    assign ma_lt    = (ma < mb);
    assign rem_init = ma_lt ? {ma, 1'b0} : {1'b0, ma};
    assign e_diff   = {2'b00, ea} - {2'b00, eb} + BIAS_E;
    assign e_init   = ma_lt ? e_diff - EW'(1) : e_diff;

    logic             rem_ge;
    logic [MAN_W+1:0] rem_sub;

    assign rem_ge  = (rem_q >= {1'b0, mb_q});
    assign rem_sub = rem_ge ? rem_q - {1'b0, mb_q} : rem_q;

    // quot_q keeps the last MAN_W+1 bits: fraction in [MAN_W:1], guard in [0]
    logic                 g_bit, sticky, rnd_up;
    logic [MAN_W:0]       frac_inc;
    logic signed [EW-1:0] e_rnd;

    assign g_bit    = quot_q[0];
    assign sticky   = |rem_q;
    assign rnd_up   = g_bit & (sticky | quot_q[1]);
    assign frac_inc = {1'b0, quot_q[MAN_W:1]} + {{MAN_W{1'b0}}, rnd_up};
    assign e_rnd    = exp_q + $signed({{(EW-1){1'b0}}, frac_inc[MAN_W]});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            sign_q      <= 1'b0;
            res_q       <= '0;
            flags_q     <= '0;
            rem_q       <= '0;
            mb_q        <= '0;
            quot_q      <= '0;
            exp_q       <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        sign_q     <= sr;
                        if (sp_hit) begin
                            res_q       <= sp_res;
                            flags_q     <= sp_flags;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            rem_q   <= rem_init;
                            mb_q    <= mb;
                            exp_q   <= e_init;
                            quot_q  <= '0;
                            cnt_q   <= '0;
                            state_q <= DIV;
                        end
                    end
                end
                DIV: begin
                    rem_q  <= rem_sub << 1;
                    quot_q <= {quot_q[MAN_W-1:0], rem_ge};
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ROUND;
                    end
                end
                ROUND: begin
                    if (e_rnd >= EXP_OVF) begin
                        res_q   <= {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        flags_q <= 5'b00101;
                    end else if (e_rnd <= EXP_ZERO) begin
                        res_q   <= {sign_q, {(W-1){1'b0}}};
                        flags_q <= 5'b00011;
                    end else begin
                        res_q   <= {sign_q, e_rnd[EXP_W-1:0], frac_inc[MAN_W-1:0]};
                        flags_q <= {4'b0000, g_bit | sticky};
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign q         = res_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Bench for fp_div_seq: single- and half-precision instances checked against an
// integer-division reference model, plus directed special, range, handshake and reset cases.
module tb_fp_div_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        s_iv, s_ir, s_ov, s_or, s_busy;
    logic [31:0] s_a, s_b, s_q;
    logic [4:0]  s_f;
    logic        h_iv, h_ir, h_ov, h_or, h_busy;
    logic [15:0] h_a, h_b, h_q;
    logic [4:0]  h_f;

    fp_div_seq #(.EXP_W(8), .MAN_W(23)) u_sp (
        .clk(clk), .rst_n(rst_n), .in_valid(s_iv), .in_ready(s_ir), .a(s_a), .b(s_b),
        .out_valid(s_ov), .out_ready(s_or), .q(s_q), .flags(s_f), .busy(s_busy)
    );

    fp_div_seq #(.EXP_W(5), .MAN_W(10)) u_hp (
        .clk(clk), .rst_n(rst_n), .in_valid(h_iv), .in_ready(h_ir), .a(h_a), .b(h_b),
        .out_valid(h_ov), .out_ready(h_or), .q(h_q), .flags(h_f), .busy(h_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: exact quotient by integer division, then round-to-nearest-even.
    function automatic void model(input int ew, input int mw, input logic [31:0] x,
                                  input logic [31:0] y, output logic [31:0] r,
                                  output logic [4:0] f, output bit sp);
        longint xv, yv, emax, bias, ex, ey, fx, fy, sgn, ma, mb, num, quo, mant;
        longint inf_v, zero_v, qnan_v;
        int     e, sh;
        bit     zx, zy, ix, iy, nx, ny, sx, sy, g, st;
        xv = longint'(x);
        yv = longint'(y);
        emax = (64'sd1 <<< ew) - 1;
        bias = (64'sd1 <<< (ew - 1)) - 1;
        ex = (xv >> mw) & emax;
        ey = (yv >> mw) & emax;
        fx = xv & ((64'sd1 <<< mw) - 1);
        fy = yv & ((64'sd1 <<< mw) - 1);
        sgn = ((xv ^ yv) >> (ew + mw)) & 1;
        zx = (ex == 0);
        zy = (ey == 0);
        ix = (ex == emax) && (fx == 0);
        iy = (ey == emax) && (fy == 0);
        nx = (ex == emax) && (fx != 0);
        ny = (ey == emax) && (fy != 0);
        sx = nx && (((fx >> (mw - 1)) & 1) == 0);
        sy = ny && (((fy >> (mw - 1)) & 1) == 0);
        inf_v  = (sgn << (ew + mw)) | (emax << mw);
        zero_v = sgn << (ew + mw);
        qnan_v = (emax << mw) | (64'sd1 <<< (mw - 1));
        sp = 1'b1;
        f  = 5'b00000;
        r  = 32'(zero_v);
        if (nx || ny) begin
            r = 32'(qnan_v);
            f = {sx | sy, 4'b0000};
        end else if ((zx && zy) || (ix && iy)) begin
            r = 32'(qnan_v);
            f = 5'b10000;
        end else if (ix) begin
            r = 32'(inf_v);
        end else if (zy) begin
            r = 32'(inf_v);
            f = 5'b01000;
        end else if (zx || iy) begin
            r = 32'(zero_v);
        end else begin
            sp = 1'b0;
            ma = (64'sd1 <<< mw) | fx;
            mb = (64'sd1 <<< mw) | fy;
            e  = int'(ex - ey + bias);
            if (ma < mb) begin
                sh = mw + 2;
                e  = e - 1;
            end else begin
                sh = mw + 1;
            end
            num  = ma << sh;
            quo  = num / mb;
            st   = (num % mb) != 0;
            g    = quo[0];
            mant = quo >> 1;
            if (g && (st || mant[0])) mant = mant + 1;
            if (mant == (64'sd1 <<< (mw + 1))) begin
                mant = mant >> 1;
                e    = e + 1;
            end
            if (longint'(e) >= emax) begin
                r = 32'(inf_v);
                f = 5'b00101;
            end else if (e <= 0) begin
                r = 32'(zero_v);
                f = 5'b00011;
            end else begin
                r = 32'((sgn << (ew + mw)) | (longint'(e) << mw) | (mant & ((64'sd1 <<< mw) - 1)));
                f = {4'b0000, g | st};
            end
        end
    endfunction

    function automatic logic [31:0] rand_op(input int ew, input int mw);
        int          emax, e;
        logic [31:0] fr, s;
        emax = (1 << ew) - 1;
        s    = 32'($urandom_range(0, 1));
        fr   = $urandom & ((32'd1 << mw) - 1);
        case ($urandom_range(0, 11))
            0:       begin e = 0; fr = '0; end
            1:       e = 0;
            2:       begin e = emax; fr = '0; end
            3:       begin e = emax; fr = fr | 32'd1; end
            4:       e = 1;
            5:       e = emax - 1;
            default: e = int'($urandom_range(1, 32'(emax - 1)));
        endcase
        return (s << (ew + mw)) | (32'(e) << mw) | fr;
    endfunction

    task automatic wait_ready(input bit half, input string tag);
        int guard = 0;
        while (!(half ? h_ir : s_ir) && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) check({tag, " in_ready timeout"}, 32'd0, 32'd1);
    endtask

    // use_k selects fixed expected values instead of the model's result
    task automatic run_op(input bit half, input logic [31:0] av, input logic [31:0] bv,
                          input string tag, input bit use_k, input logic [31:0] kq,
                          input logic [4:0] kf);
        logic [31:0] eq, gq;
        logic [4:0]  ef, gf;
        bit          sp;
        int          lat;
        model(half ? 5 : 8, half ? 10 : 23, av, bv, eq, ef, sp);
        if (use_k) begin
            eq = kq;
            ef = kf;
        end
        wait_ready(half, tag);
        @(negedge clk);
        if (half) begin
            h_iv = 1'b1; h_a = av[15:0]; h_b = bv[15:0];
        end else begin
            s_iv = 1'b1; s_a = av; s_b = bv;
        end
        @(posedge clk); #1;
        s_iv = 1'b0;
        h_iv = 1'b0;
        s_a  = $urandom;
        s_b  = $urandom;
        h_a  = 16'($urandom);
        h_b  = 16'($urandom);
        lat = 1;
        while (!(half ? h_ov : s_ov) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        gq = half ? {16'h0000, h_q} : s_q;
        gf = half ? h_f : s_f;
        check({tag, " latency"}, 32'(lat), sp ? 32'd1 : (half ? 32'd14 : 32'd27));
        check({tag, " q"}, gq, eq);
        check({tag, " flags"}, {27'd0, gf}, {27'd0, ef});
        @(posedge clk); #1;
        check({tag, " out_valid drop"}, {31'd0, half ? h_ov : s_ov}, 32'd0);
    endtask

    task automatic hold_test();
        logic [31:0] q0;
        logic [4:0]  f0;
        int          lat;
        s_or = 1'b0;
        wait_ready(1'b0, "hold");
        @(negedge clk);
        s_iv = 1'b1; s_a = 32'h40C00000; s_b = 32'h40000000;
        @(posedge clk); #1;
        s_iv = 1'b0;
        lat = 1;
        while (!s_ov && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        q0 = s_q;
        f0 = s_f;
        check("hold first q", q0, 32'h40400000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            s_iv = 1'b1;
            s_a  = $urandom;
            s_b  = $urandom;
            @(posedge clk); #1;
            check("hold q", s_q, q0);
            check("hold flags", {27'd0, s_f}, {27'd0, f0});
            check("hold out_valid", {31'd0, s_ov}, 32'd1);
            check("hold in_ready", {31'd0, s_ir}, 32'd0);
        end
        @(negedge clk);
        s_iv = 1'b0;
        s_or = 1'b1;
        @(posedge clk); #1;
        check("hold release out_valid", {31'd0, s_ov}, 32'd0);
        check("hold release in_ready", {31'd0, s_ir}, 32'd1);
    endtask

    task automatic reset_test();
        wait_ready(1'b0, "rst");
        @(negedge clk);
        s_iv = 1'b1; s_a = 32'h3F800000; s_b = 32'h40400000;
        @(posedge clk); #1;
        s_iv = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst busy in DIV", {31'd0, s_busy}, 32'd1);
        check("rst in_ready in DIV", {31'd0, s_ir}, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("rst out_valid", {31'd0, s_ov}, 32'd0);
        check("rst q", s_q, 32'd0);
        check("rst busy", {31'd0, s_busy}, 32'd0);
        check("rst in_ready", {31'd0, s_ir}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("rst no result", {31'd0, s_ov}, 32'd0);
        run_op(1'b0, 32'h3F800000, 32'h40400000, "post-rst 1/3", 1'b1, 32'h3EAAAAAB, 5'b00001);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        s_iv = 1'b0; s_or = 1'b1; s_a = '0; s_b = '0;
        h_iv = 1'b0; h_or = 1'b1; h_a = '0; h_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", {31'd0, s_ov}, 32'd0);
        check("reset q", s_q, 32'd0);
        check("reset flags", {27'd0, s_f}, 32'd0);
        check("reset busy", {31'd0, s_busy}, 32'd0);
        check("reset in_ready", {31'd0, s_ir}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("post-reset in_ready", {31'd0, s_ir}, 32'd1);

        run_op(1'b0, 32'h40C00000, 32'h40000000, "6/2",      1'b1, 32'h40400000, 5'b00000);
        run_op(1'b0, 32'h3F800000, 32'h40400000, "1/3",      1'b1, 32'h3EAAAAAB, 5'b00001);
        run_op(1'b0, 32'h3F800000, 32'h00000000, "1/0",      1'b1, 32'h7F800000, 5'b01000);
        run_op(1'b0, 32'hBF800000, 32'h00000000, "-1/0",     1'b1, 32'hFF800000, 5'b01000);
        run_op(1'b0, 32'h00000000, 32'h00000000, "0/0",      1'b1, 32'h7FC00000, 5'b10000);
        run_op(1'b0, 32'h7F800000, 32'h40000000, "inf/2",    1'b1, 32'h7F800000, 5'b00000);
        run_op(1'b0, 32'h7F000000, 32'h3E800000, "overflow", 1'b1, 32'h7F800000, 5'b00101);
        run_op(1'b0, 32'h00800000, 32'h40000000, "underflow",1'b1, 32'h00000000, 5'b00011);
        run_op(1'b0, 32'h7F800001, 32'h3F800000, "sNaN",     1'b1, 32'h7FC00000, 5'b10000);
        run_op(1'b0, 32'h7FC00001, 32'h3F800000, "qNaN",     1'b1, 32'h7FC00000, 5'b00000);
        run_op(1'b0, 32'h00400000, 32'h3F800000, "subnorm",  1'b1, 32'h00000000, 5'b00000);
        run_op(1'b1, 32'h00004600, 32'h00004000, "h 6/2",    1'b1, 32'h00004200, 5'b00000);
        run_op(1'b1, 32'h00003C00, 32'h00004200, "h 1/3",    1'b1, 32'h00003555, 5'b00001);

        hold_test();
        reset_test();

        for (int i = 0; i < 150; i++) begin
            run_op(1'b0, rand_op(8, 23), rand_op(8, 23), "rand sp", 1'b0, 32'd0, 5'd0);
        end
        for (int i = 0; i < 100; i++) begin
            run_op(1'b1, rand_op(5, 10), rand_op(5, 10), "rand hp", 1'b0, 32'd0, 5'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_div_seq.md
Name: fp_div_seq

Overview:
- Parametrised, self-contained IEEE-754 floating-point divider with a valid/ready handshake on both sides.
- Computes the mantissa by radix-2 restoring division, one quotient bit per cycle. No external multiplier or adder is used.
- Rounding is round-to-nearest-even. The block returns the full exception flag set, flushes subnormals to zero, and supports any exponent/mantissa width.
- Sits beside the single-precision multiplier and adder as the FPU divide unit.

Parameters:
- EXP_W, 8, exponent width in bits; BIAS = 2^(EXP_W-1)-1.
- MAN_W, 23, stored mantissa (fraction) width in bits; the word width is W = 1+EXP_W+MAN_W.

Ports:
- clk  input  1  clock; all flops on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a and b are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  W  dividend.
- b  input  W  divisor.
- out_valid  output  1  q and flags are valid.
- out_ready  input  1  consumer accepts the result.
- q  output  W  quotient a/b.
- flags  output  5  {invalid, divzero, overflow, underflow, inexact}; applies to the current result only, not sticky.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; out_valid=0, q=0, flags=0, busy=0. in_ready=0 while rst_n is low, then 1.
- Reset mid-operation aborts the operation; no result is produced.
- States: IDLE, DIV, ROUND, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch the operands and classify them.
  - A subnormal input (exp=0, frac!=0) is treated as a signed zero.
  - The result sign is sa^sb.
- Special cases: the result is loaded at acceptance and the state goes directly to DONE (out_valid one cycle after acceptance).
  - Any NaN input gives the canonical qNaN {0, all-ones exp, 1, zeros}. invalid is set only if a NaN input is signalling (frac MSB = 0).
  - 0/0 or inf/inf gives qNaN, invalid=1.
  - finite nonzero/0 gives signed inf, divzero=1.
  - inf/finite gives signed inf, no flags.
  - 0/finite-nonzero or finite/inf gives signed zero, no flags.
- Normal path setup at acceptance:
  - ma={1,fa}, mb={1,fb}.
  - e = ea-eb+BIAS, signed, EXP_W+2 bits.
  - If ma<mb: ma<<=1, e-=1.
  - The counter is cleared and the state goes to DIV.
- DIV: one restoring step per cycle.
  - If rem>=mb: qbit=1, rem-=mb; else qbit=0. Then rem<<=1.
  - MAN_W+2 cycles produce 1 integer bit, MAN_W fraction bits and 1 guard bit g.
  - At exit, sticky s = (rem!=0). The state then goes to ROUND.
- ROUND (1 cycle):
  - Round up iff g&(s|lsb).
  - On mantissa carry-out: fraction=0, e+=1.
  - inexact = g|s.
  - If e >= 2^EXP_W-1: q = signed inf, overflow=1, inexact=1.
  - Else if e <= 0: q = signed zero (flush), underflow=1, inexact=1.
  - Otherwise pack {sign, e[EXP_W-1:0], fraction}.
  - The state goes to DONE.
- DONE: out_valid=1. q and flags are held stable until out_ready.
  - On out_valid&&out_ready the state goes to IDLE and out_valid drops the next cycle.
  - in_ready=0 here, so no same-cycle accept; throughput is one operation per occupancy.
- Latency (acceptance at edge T):
  - Normal operands: out_valid first high at T+MAN_W+4 (27 cycles for defaults).
  - Special cases: out_valid at T+1.
- in_valid outside IDLE is ignored. Operand changes after acceptance have no effect.
- out_ready while out_valid=0 has no effect.
- Widths: the remainder register is MAN_W+2 bits and the counter is clog2(MAN_W+3) bits. No arithmetic wraps.

Test Plan:
- Exact divide: a=0x40C00000 (6.0), b=0x40000000 (2.0), out_ready=1 -> q=0x40400000, flags=0, out_valid exactly 27 cycles after acceptance.
- Inexact divide: a=0x3F800000, b=0x40400000 -> q=0x3EAAAAAB (rounded up), flags=00001.
- Special cases, each with out_valid one cycle after acceptance:
  - 0x3F800000/0x00000000 -> 0x7F800000, flags=01000.
  - 0xBF800000/0x00000000 -> 0xFF800000, flags=01000.
  - 0x00000000/0x00000000 -> 0x7FC00000, flags=10000.
  - 0x7F800000/0x40000000 -> 0x7F800000, flags=0.
- Range limits:
  - Overflow: 0x7F000000/0x3E800000 -> 0x7F800000, flags=00101.
  - Underflow: 0x00800000/0x40000000 -> 0x00000000, flags=00011.
- Handshake and reset:
  - Hold out_ready=0 for 10 cycles in DONE -> q/flags stable, in_ready=0, in_valid pulses ignored.
  - Pulse rst_n low mid-DIV -> out_valid=0, q=0; the next operation completes correctly.
- Half-precision instance (EXP_W=5, MAN_W=10): a=0x4600, b=0x4000 -> q=0x4200, flags=0, latency 14 cycles. Also 0x3C00/0x4200 -> 0x3555, flags=00001.
